lsu: RTL and testbench

//   Load/store stage of the L2 core: sits between EXU and WBU in the pipeline.
//   - Accepts one instruction at a time from EXU over a valid/ready handshake.
//   - Runs the data-RAM request/grant/response transaction.
//   - Aligns and extends load data, builds store byte masks.
//   - Presents the l2w_* bundle that WBU consumes, again over valid/ready.

---
 rtl/lsu.sv | 194 +++++++++++++++++++
 tb/tb_lsu.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store stage between EXU and WBU: one instruction in flight, runs the
// data-RAM req/gnt/rvalid transaction, aligns load data and builds store lanes.
module lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int GPRS_W = 5,
    parameter int ARGS_W = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_e2l_valid,
    output logic              o_lsu_ready,
    input  logic [ADDR_W-1:0] i_e2l_pc,
    input  logic [DATA_W-1:0] i_e2l_alu_res,
    input  logic [DATA_W-1:0] i_e2l_st_data,
    input  logic [GPRS_W-1:0] i_e2l_wr_id,
    input  logic              i_e2l_ctr_reg_wr_en,
    input  logic [ARGS_W-1:0] i_e2l_ctr_reg_wr_src,
    input  logic              i_e2l_ctr_ram_rd_en,
    input  logic              i_e2l_ctr_ram_wr_en,
    input  logic [2:0]        i_e2l_ctr_ram_byt,
    output logic              o_ram_req,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [3:0]        o_ram_wmask,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic              i_ram_gnt,
    input  logic              i_ram_rvalid,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic              o_l2w_valid,
    input  logic              i_wbu_ready,
    output logic [ADDR_W-1:0] o_l2w_pc,
    output logic [DATA_W-1:0] o_l2w_alu_res,
    output logic [GPRS_W-1:0] o_l2w_wr_id,
    output logic              o_l2w_ctr_reg_wr_en,
    output logic [ARGS_W-1:0] o_l2w_ctr_reg_wr_src,
    output logic [DATA_W-1:0] o_l2w_ram_res,
    output logic              o_lsu_misalign
);

    // state | meaning
    // IDLE  | ready for a new instruction from EXU
    // REQ   | data-RAM request held until granted
    // WAIT  | granted load, waiting for read data
    // DONE  | result presented to WBU
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] st_data_q;
    logic              we_q;
    logic [2:0]        byt_q;
    logic              ready_q;
    logic              req_q;
    logic              valid_q;
    logic              misalign_q;
    logic              reg_wr_en_q;
    logic [DATA_W-1:0] ram_res_q;

    logic              in_ram_op;
    logic              in_mis;
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] ld_ext;
    logic [3:0]        wmask;
    logic [DATA_W-1:0] wdata;

    always_comb begin
        in_ram_op = i_e2l_ctr_ram_rd_en | i_e2l_ctr_ram_wr_en;
        in_mis    = 1'b0;
        case (i_e2l_ctr_ram_byt[1:0])
            2'b01:   in_mis = i_e2l_alu_res[0];
            2'b10:   in_mis = |i_e2l_alu_res[1:0];
            default: in_mis = 1'b0;
        endcase
        in_mis = in_mis & in_ram_op;
    end

    always_comb begin
        rd_shift = i_ram_rdata >> {alu_q[1:0], 3'b000};
        case (byt_q)
            3'b000:  ld_ext = {{(DATA_W-8){rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  ld_ext = {{(DATA_W-16){rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  ld_ext = {{(DATA_W-8){1'b0}}, rd_shift[7:0]};
            3'b101:  ld_ext = {{(DATA_W-16){1'b0}}, rd_shift[15:0]};
            default: ld_ext = i_ram_rdata;
        endcase
    end

    always_comb begin
        case (byt_q[1:0])
            2'b00: begin
                wmask = 4'b0001 << alu_q[1:0];
                wdata = {4{st_data_q[7:0]}};
            end
            2'b01: begin
                wmask = alu_q[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data_q[15:0]}};
            end
            default: begin
                wmask = 4'b1111;
                wdata = st_data_q;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state                <= IDLE;
            alu_q                <= '0;
            st_data_q            <= '0;
            we_q                 <= 1'b0;
            byt_q                <= '0;
            ready_q              <= 1'b1;
            req_q                <= 1'b0;
            valid_q              <= 1'b0;
            misalign_q           <= 1'b0;
            reg_wr_en_q          <= 1'b0;
            ram_res_q            <= '0;
            o_l2w_pc             <= '0;
            o_l2w_wr_id          <= '0;
            o_l2w_ctr_reg_wr_src <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_e2l_valid) begin
                        o_l2w_pc             <= i_e2l_pc;
                        alu_q                <= i_e2l_alu_res;
                        st_data_q            <= i_e2l_st_data;
                        o_l2w_wr_id          <= i_e2l_wr_id;
                        o_l2w_ctr_reg_wr_src <= i_e2l_ctr_reg_wr_src;
                        we_q                 <= i_e2l_ctr_ram_wr_en;
                        byt_q                <= i_e2l_ctr_ram_byt;
                        reg_wr_en_q          <= i_e2l_ctr_reg_wr_en & ~in_mis;
                        misalign_q           <= in_mis;
                        ram_res_q            <= '0;
                        ready_q              <= 1'b0;
                        if (in_mis || !in_ram_op) begin
                            state   <= DONE;
                            valid_q <= 1'b1;
                        end else begin
                            state <= REQ;
                            req_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (i_ram_gnt) begin
                        req_q <= 1'b0;
                        // a store wins over a load when both enables are set
                        if (we_q) begin
                            state   <= DONE;
                            valid_q <= 1'b1;
                        end else if (i_ram_rvalid) begin
                            ram_res_q <= ld_ext;
                            state     <= DONE;
                            valid_q   <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (i_ram_rvalid) begin
                        ram_res_q <= ld_ext;
                        state     <= DONE;
                        valid_q   <= 1'b1;
                    end
                end
                DONE: begin
                    if (i_wbu_ready) begin
                        state      <= IDLE;
                        valid_q    <= 1'b0;
                        ready_q    <= 1'b1;
                        misalign_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_lsu_ready         = ready_q;
    assign o_ram_req           = req_q;
    assign o_ram_we            = we_q;
    assign o_ram_addr          = {alu_q[ADDR_W-1:2], 2'b00};
    assign o_ram_wmask         = we_q ? wmask : 4'b0000;
    assign o_ram_wdata         = wdata;
    assign o_l2w_valid         = valid_q;
    assign o_l2w_alu_res       = alu_q;
    assign o_l2w_ctr_reg_wr_en = reg_wr_en_q;
    assign o_l2w_ram_res       = ram_res_q;
    assign o_lsu_misalign      = misalign_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed cases plus random loads/stores/ALU ops against a
// behavioural model of alignment, extension and store lane rules.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        e2l_valid;
    logic        lsu_ready;
    logic [31:0] e2l_pc;
    logic [31:0] e2l_alu_res;
    logic [31:0] e2l_st_data;
    logic [4:0]  e2l_wr_id;
    logic        e2l_reg_wr_en;
    logic [2:0]  e2l_reg_wr_src;
    logic        e2l_rd_en;
    logic        e2l_wr_en;
    logic [2:0]  e2l_byt;
    logic        ram_req;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [3:0]  ram_wmask;
    logic [31:0] ram_wdata;
    logic        ram_gnt;
    logic        ram_rvalid;
    logic [31:0] ram_rdata;
    logic        l2w_valid;
    logic        wbu_ready;
    logic [31:0] l2w_pc;
    logic [31:0] l2w_alu_res;
    logic [4:0]  l2w_wr_id;
    logic        l2w_reg_wr_en;
    logic [2:0]  l2w_reg_wr_src;
    logic [31:0] l2w_ram_res;
    logic        lsu_misalign;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_e2l_valid         (e2l_valid),
        .o_lsu_ready         (lsu_ready),
        .i_e2l_pc            (e2l_pc),
        .i_e2l_alu_res       (e2l_alu_res),
        .i_e2l_st_data       (e2l_st_data),
        .i_e2l_wr_id         (e2l_wr_id),
        .i_e2l_ctr_reg_wr_en (e2l_reg_wr_en),
        .i_e2l_ctr_reg_wr_src(e2l_reg_wr_src),
        .i_e2l_ctr_ram_rd_en (e2l_rd_en),
        .i_e2l_ctr_ram_wr_en (e2l_wr_en),
        .i_e2l_ctr_ram_byt   (e2l_byt),
        .o_ram_req           (ram_req),
        .o_ram_we            (ram_we),
        .o_ram_addr          (ram_addr),
        .o_ram_wmask         (ram_wmask),
        .o_ram_wdata         (ram_wdata),
        .i_ram_gnt           (ram_gnt),
        .i_ram_rvalid        (ram_rvalid),
        .i_ram_rdata         (ram_rdata),
        .o_l2w_valid         (l2w_valid),
        .i_wbu_ready         (wbu_ready),
        .o_l2w_pc            (l2w_pc),
        .o_l2w_alu_res       (l2w_alu_res),
        .o_l2w_wr_id         (l2w_wr_id),
        .o_l2w_ctr_reg_wr_en (l2w_reg_wr_en),
        .o_l2w_ctr_reg_wr_src(l2w_reg_wr_src),
        .o_l2w_ram_res       (l2w_ram_res),
        .o_lsu_misalign      (lsu_misalign)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int acc_size(input logic [2:0] byt);
        case (byt[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input int lane, input logic [2:0] byt);
        longint unsigned part;
        int size;
        size = acc_size(byt);
        if (size == 4) return w;
        part = (longint'(w) >> (8 * lane)) % (longint'(1) << (8 * size));
        if (!byt[2] && part >= (longint'(1) << (8 * size - 1)))
            return 32'(longint'(part) - (longint'(1) << (8 * size)));
        return 32'(part);
    endfunction

    task automatic run_op(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] sd,
                          input logic [4:0] wid, input logic wen, input logic [2:0] src,
                          input logic rd, input logic wr, input logic [2:0] byt,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                          input int wbu_dly);
        bit is_st, is_ld, mis;
        int size, lane;
        logic [31:0] exp_res, exp_wdata;
        logic [3:0]  exp_mask;
        is_st = wr;
        is_ld = rd && !wr;
        size  = acc_size(byt);
        lane  = int'(addr % 4);
        mis   = (is_st || is_ld) && (addr % size != 0);
        exp_res = (is_ld && !mis) ? model_load(rdata, lane, byt) : 32'h0;
        case (size)
            1:       begin exp_mask = 4'(1 << lane);               exp_wdata = sd[7:0] * 32'h0101_0101; end
            2:       begin exp_mask = 4'(3 << (addr % 4 / 2 * 2)); exp_wdata = sd[15:0] * 32'h0001_0001; end
            default: begin exp_mask = 4'hF;                        exp_wdata = sd; end
        endcase

        check("ready_idle", lsu_ready, 1);
        e2l_pc = pc; e2l_alu_res = addr; e2l_st_data = sd; e2l_wr_id = wid;
        e2l_reg_wr_en = wen; e2l_reg_wr_src = src; e2l_rd_en = rd; e2l_wr_en = wr; e2l_byt = byt;
        e2l_valid = 1'b1;
        tick();
        e2l_valid = 1'b0;
        e2l_pc = $urandom; e2l_alu_res = $urandom; e2l_st_data = $urandom; e2l_byt = 3'($urandom);
        check("ready_busy", lsu_ready, 0);

        if ((is_st || is_ld) && !mis) begin
            check("req_up", ram_req, 1);
            check("req_addr", ram_addr, addr & 32'hFFFF_FFFC);
            check("req_we", ram_we, is_st);
            if (is_st) begin
                check("st_wmask", ram_wmask, exp_mask);
                check("st_wdata", ram_wdata, exp_wdata);
            end
            for (int i = 0; i < gnt_dly; i++) begin
                tick();
                check("req_hold", ram_req, 1);
                check("req_hold_addr", ram_addr, addr & 32'hFFFF_FFFC);
                check("no_valid_req", l2w_valid, 0);
            end
            ram_gnt = 1'b1;
            if (is_ld && rv_dly == 0) begin
                ram_rvalid = 1'b1;
                ram_rdata  = rdata;
            end
            tick();
            ram_gnt = 1'b0; ram_rvalid = 1'b0; ram_rdata = $urandom;
            if (is_ld && rv_dly > 0) begin
                for (int i = 1; i < rv_dly; i++) begin
                    check("wait_no_req", ram_req, 0);
                    check("wait_no_valid", l2w_valid, 0);
                    tick();
                end
                check("wait_no_req", ram_req, 0);
                ram_rvalid = 1'b1;
                ram_rdata  = rdata;
                tick();
                ram_rvalid = 1'b0; ram_rdata = $urandom;
            end
        end else begin
            check("no_req", ram_req, 0);
        end

        check("valid", l2w_valid, 1);
        check("pc", l2w_pc, pc);
        check("alu_res", l2w_alu_res, addr);
        check("wr_id", l2w_wr_id, wid);
        check("wr_src", l2w_reg_wr_src, src);
        check("reg_wr_en", l2w_reg_wr_en, wen && !mis);
        check("ram_res", l2w_ram_res, exp_res);
        check("misalign", lsu_misalign, mis);

        for (int i = 0; i < wbu_dly; i++) begin
            e2l_valid = 1'b1;
            e2l_pc = $urandom;
            tick();
            check("hold_valid", l2w_valid, 1);
            check("hold_ready", lsu_ready, 0);
            check("hold_pc", l2w_pc, pc);
            check("hold_res", l2w_ram_res, exp_res);
            check("hold_no_req", ram_req, 0);
        end
        e2l_valid = 1'b0;
        wbu_ready = 1'b1;
        tick();
        wbu_ready = 1'b0;
        check("released_valid", l2w_valid, 0);
        check("released_ready", lsu_ready, 1);
    endtask

    initial begin
        logic [2:0] ld_byts [5];
        logic [2:0] byt;
        logic rd, wr;
        ld_byts = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        rst_n = 1'b0; e2l_valid = 1'b0; wbu_ready = 1'b0;
        e2l_pc = '0; e2l_alu_res = '0; e2l_st_data = '0; e2l_wr_id = '0;
        e2l_reg_wr_en = 1'b0; e2l_reg_wr_src = '0; e2l_rd_en = 1'b0; e2l_wr_en = 1'b0; e2l_byt = '0;
        ram_gnt = 1'b0; ram_rvalid = 1'b0; ram_rdata = '0;
        tick(); tick();
        check("rst_ready", lsu_ready, 1);
        check("rst_req", ram_req, 0);
        check("rst_valid", l2w_valid, 0);
        check("rst_pc", l2w_pc, 0);
        check("rst_res", l2w_ram_res, 0);
        check("rst_mis", lsu_misalign, 0);
        rst_n = 1'b1;
        tick();

        // ALU op with WBU stalling for 5 cycles
        run_op(32'h100, 32'h1234, 32'h0, 5'd3, 1'b1, 3'd1, 1'b0, 1'b0, 3'b010, 0, 0, 32'h0, 5);
        run_op(32'h104, 32'h1003, 32'h0, 5'd4, 1'b1, 3'd2, 1'b1, 1'b0, 3'b000, 1, 2, 32'h80FF_0000, 0);
        check("lb_value", l2w_ram_res, 32'hFFFF_FF80);
        run_op(32'h108, 32'h1003, 32'h0, 5'd5, 1'b1, 3'd2, 1'b1, 1'b0, 3'b100, 1, 2, 32'h80FF_0000, 0);
        check("lbu_value", l2w_ram_res, 32'h0000_0080);
        run_op(32'h10C, 32'h2002, 32'h0000_ABCD, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'b001, 2, 0, 32'h0, 1);
        run_op(32'h110, 32'h3001, 32'h0, 5'd6, 1'b1, 3'd2, 1'b1, 1'b0, 3'b010, 0, 0, 32'h0, 0);
        run_op(32'h114, 32'h2002, 32'h0, 5'd7, 1'b1, 3'd2, 1'b1, 1'b0, 3'b101, 0, 0, 32'hBEEF_1234, 0);
        run_op(32'h118, 32'h2001, 32'h5A, 5'd8, 1'b0, 3'd0, 1'b1, 1'b1, 3'b000, 0, 0, 32'h0, 0);

        // reset while waiting for read data; the late rvalid must not land
        e2l_pc = 32'h200; e2l_alu_res = 32'h4000; e2l_rd_en = 1'b1; e2l_wr_en = 1'b0;
        e2l_byt = 3'b010; e2l_reg_wr_en = 1'b1;
        e2l_valid = 1'b1;
        tick();
        e2l_valid = 1'b0;
        check("rw_req", ram_req, 1);
        ram_gnt = 1'b1;
        tick();
        ram_gnt = 1'b0;
        check("rw_wait_req", ram_req, 0);
        rst_n = 1'b0;
        #1;
        check("rw_rst_req", ram_req, 0);
        check("rw_rst_valid", l2w_valid, 0);
        check("rw_rst_ready", lsu_ready, 1);
        tick();
        rst_n = 1'b1;
        ram_rvalid = 1'b1; ram_rdata = 32'hDEAD_BEEF;
        tick();
        ram_rvalid = 1'b0;
        check("late_rv_valid", l2w_valid, 0);
        check("late_rv_ready", lsu_ready, 1);
        check("late_rv_res", l2w_ram_res, 0);

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 3))
                0:       begin rd = 1'b0; wr = 1'b0; end
                1:       begin rd = 1'b0; wr = 1'b1; end
                2:       begin rd = 1'b1; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b0; end
            endcase
            byt = wr ? 3'($urandom_range(0, 2)) : ld_byts[$urandom_range(0, 4)];
            run_op($urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), 3'($urandom),
                   rd, wr, byt, $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                   $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
